// File: rtl/imem_boot_controller.sv
// Instruction-memory boot controller: loads a byte stream into RAM as LE words (BOOT), then serves fetches (RUN).
// Optional IMEM_BOUNDS_CHECK_EN adds fetch_fault and returns NOP for out-of-range/misaligned fetches.
module imem_boot_controller #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_pc,
  output logic          fetch_stall,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          load_done,
  output logic          load_overflow,
  output logic [AW:0]   words_loaded,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
`ifdef IMEM_BOUNDS_CHECK_EN
  output logic          fetch_fault,
`endif
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t       state, state_nx;
  logic [1:0]   bidx, bidx_nx;
  logic [23:0]  lanes, lanes_nx;
  logic [AW:0]  wcnt, wcnt_nx;
  logic         ovf, ovf_nx;
  logic         full;
  logic [31:0]  word;
  logic         rd, rd_q, flt, flt_q;
  logic [31:0]  instr_q;

  // wcnt doubles as the write address; it saturates at DEPTH
  assign full = (wcnt == (AW+1)'(DEPTH));
  assign word = {8'h00, lanes} | ({24'h0, ld_data} << {bidx, 3'b000});

`ifdef IMEM_BOUNDS_CHECK_EN
  logic oob;
  assign oob = (32'(fetch_pc[31:2]) >= 32'(wcnt)) || (fetch_pc[1:0] != 2'b00);
`else
  logic unused_pc;
  assign unused_pc = ^{fetch_pc[31:AW+2], fetch_pc[1:0]};
`endif

  always_comb begin
    state_nx  = state;
    bidx_nx   = bidx;
    lanes_nx  = lanes;
    wcnt_nx   = wcnt;
    ovf_nx    = ovf;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = wcnt[AW-1:0];
    mem_wdata = word;
    rd        = 1'b0;
    flt       = 1'b0;
    case (state)
      BOOT: begin
        if (reload) begin
          bidx_nx  = '0;
          lanes_nx = '0;
          wcnt_nx  = '0;
          ovf_nx   = 1'b0;
        end else if (ld_valid) begin
          if (full) begin
            ovf_nx = 1'b1;
          end else if (bidx == 2'd3 || ld_last) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            wcnt_nx  = wcnt + 1'b1;
            bidx_nx  = '0;
            lanes_nx = '0;
          end else begin
            bidx_nx  = bidx + 1'b1;
            lanes_nx = word[23:0];
          end
          if (ld_last) begin
            state_nx = RUN;
            bidx_nx  = '0;
            lanes_nx = '0;
          end
        end
      end
      RUN: begin
        mem_addr = fetch_pc[AW+1:2];
`ifdef IMEM_BOUNDS_CHECK_EN
        rd  = fetch_req && !oob;
        flt = fetch_req && oob;
`else
        rd  = fetch_req;
`endif
        mem_en = rd;
        // the fetch accepted alongside reload still completes next cycle
        if (reload) begin
          state_nx = BOOT;
          bidx_nx  = '0;
          lanes_nx = '0;
          wcnt_nx  = '0;
          ovf_nx   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= BOOT;
      bidx    <= '0;
      lanes   <= '0;
      wcnt    <= '0;
      ovf     <= 1'b0;
      rd_q    <= 1'b0;
      flt_q   <= 1'b0;
      instr_q <= NOP_INSTR;
    end else begin
      state <= state_nx;
      bidx  <= bidx_nx;
      lanes <= lanes_nx;
      wcnt  <= wcnt_nx;
      ovf   <= ovf_nx;
      rd_q  <= rd;
      flt_q <= flt;
      if (fetch_valid) instr_q <= fetch_instr;
    end
  end

  assign ld_ready      = (state == BOOT);
  assign fetch_stall   = (state == BOOT);
  assign load_done     = (state == RUN);
  assign load_overflow = ovf;
  assign words_loaded  = wcnt;
  assign fetch_valid   = rd_q | flt_q;
  assign fetch_instr   = flt_q ? NOP_INSTR : (rd_q ? mem_rdata : instr_q);
`ifdef IMEM_BOUNDS_CHECK_EN
  assign fetch_fault   = flt_q;
`endif

endmodule

// File: tb/tb_imem_boot_controller.sv
// Bench for imem_boot_controller: queue-based reference model checked every cycle, plus directed literal checks.
module tb_imem_boot_controller;
  localparam int          DEPTH = 8;
  localparam int          AW    = 3;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ld_valid, ld_last, ld_ready, reload, fetch_req;
  logic [7:0]    ld_data;
  logic [31:0]   fetch_pc, fetch_instr, mem_wdata, mem_rdata;
  logic          fetch_stall, fetch_valid, load_done, load_overflow, mem_en, mem_we;
  logic [AW:0]   words_loaded;
  logic [AW-1:0] mem_addr;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic          fetch_fault;
`endif

  imem_boot_controller #(.DEPTH(DEPTH), .AW(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_stall(fetch_stall), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .load_done(load_done), .load_overflow(load_overflow), .words_loaded(words_loaded),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef IMEM_BOUNDS_CHECK_EN
    .fetch_fault(fetch_fault),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: mode, pending bytes, word count, RAM image, one-deep fetch response
  bit          m_run, m_ovf, m_pv, m_pf;
  logic [7:0]  m_bytes [$];
  int          m_wcnt;
  logic [31:0] m_pi, m_last;
  logic [31:0] m_mem [DEPTH];

  always @(negedge clk) begin : cmp
    bit          e_en, bad;
    logic [31:0] e_addr, e_wd;
    if (!reset_n) begin
      m_run = 0; m_ovf = 0; m_pv = 0; m_pf = 0; m_wcnt = 0; m_last = NOP;
      m_bytes.delete();
    end else if (chk_en) begin
      e_en = 0; e_addr = 0; e_wd = 0; bad = 0;
      if (!m_run) begin
        if (!reload && ld_valid && m_wcnt < DEPTH && (m_bytes.size() == 3 || ld_last)) begin
          e_en = 1;
          e_addr = 32'(m_wcnt);
          for (int i = 0; i < m_bytes.size(); i++) e_wd |= 32'(m_bytes[i]) << (8 * i);
          e_wd |= 32'(ld_data) << (8 * m_bytes.size());
        end
      end else begin
`ifdef IMEM_BOUNDS_CHECK_EN
        bad = (fetch_pc[1:0] != 0) || ((fetch_pc >> 2) >= 32'(m_wcnt));
`endif
        e_en = fetch_req && !bad;
        e_addr = (fetch_pc >> 2) % DEPTH;
      end
      chk("ld_ready", 32'(ld_ready), 32'(!m_run));
      chk("fetch_stall", 32'(fetch_stall), 32'(!m_run));
      chk("load_done", 32'(load_done), 32'(m_run));
      chk("words_loaded", 32'(words_loaded), 32'(m_wcnt));
      chk("load_overflow", 32'(load_overflow), 32'(m_ovf));
      chk("fetch_valid", 32'(fetch_valid), 32'(m_pv));
      chk("fetch_instr", fetch_instr, m_pv ? m_pi : m_last);
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("fetch_fault", 32'(fetch_fault), 32'(m_pv && m_pf));
`endif
      chk("mem_en", 32'(mem_en), 32'(e_en));
      if (e_en) begin
        chk("mem_we", 32'(mem_we), 32'(!m_run));
        chk("mem_addr", 32'(mem_addr), e_addr);
        if (!m_run) chk("mem_wdata", mem_wdata, e_wd);
      end
      // advance model to the state after the coming rising edge
      if (m_pv) m_last = m_pi;
      m_pv = 0; m_pf = 0;
      if (!m_run) begin
        if (reload) begin
          m_bytes.delete(); m_wcnt = 0; m_ovf = 0;
        end else if (ld_valid) begin
          if (m_wcnt >= DEPTH) m_ovf = 1;
          else if (e_en) begin
            m_mem[m_wcnt] = e_wd; m_wcnt++; m_bytes.delete();
          end else m_bytes.push_back(ld_data);
          if (ld_last) begin m_run = 1; m_bytes.delete(); end
        end
      end else begin
        if (fetch_req) begin
          m_pv = 1; m_pf = bad;
          m_pi = bad ? NOP : m_mem[e_addr];
        end
        if (reload) begin m_run = 0; m_bytes.delete(); m_wcnt = 0; m_ovf = 0; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  logic [7:0] bq [$];

  // send bq as one program; gaps inserts random idle cycles, rl_pct injects reload pulses
  task automatic send(input bit gaps, input int rl_pct);
    for (int i = 0; i < bq.size(); i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        ld_valid = 0; ld_data = 8'($urandom); ld_last = 1'($urandom); reload = 0; step();
      end
      ld_valid = 1; ld_data = bq[i]; ld_last = (i == bq.size() - 1);
      reload = ($urandom_range(0, 99) < rl_pct);
      fetch_req = 1'($urandom); fetch_pc = $urandom;
      step();
    end
    ld_valid = 0; ld_last = 0; reload = 0; fetch_req = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ram[i] = 0; m_mem[i] = 0; end
    mem_rdata = 0;
    ld_valid = 0; ld_data = 0; ld_last = 0; reload = 0; fetch_req = 0; fetch_pc = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst ld_ready", 32'(ld_ready), 1);
    chk("rst fetch_stall", 32'(fetch_stall), 1);
    chk("rst fetch_instr", fetch_instr, NOP);
    chk("rst fetch_valid", 32'(fetch_valid), 0);
    chk("rst load_done", 32'(load_done), 0);
    chk("rst words_loaded", 32'(words_loaded), 0);
    chk("rst mem_en", 32'(mem_en), 0);
    reset_n = 1; chk_en = 1;

    // two-word program
    bq = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h90, 8'h00};
    send(0, 0);
    chk("t1 load_done", 32'(load_done), 1);
    chk("t1 words_loaded", 32'(words_loaded), 2);
    chk("t1 ram0", ram[0], 32'h00A00093);
    chk("t1 ram1", ram[1], 32'h00900113);

    // back-to-back fetches
    fetch_req = 1; fetch_pc = 0; step();
    chk("t2 instr0", fetch_instr, 32'h00A00093);
    fetch_pc = 4; step();
    chk("t2 instr1", fetch_instr, 32'h00900113);
    fetch_pc = 0; step();
    chk("t2 instr2", fetch_instr, 32'h00A00093);
    fetch_req = 0; step();
    chk("t2 idle valid", 32'(fetch_valid), 0);
    chk("t2 hold instr", fetch_instr, 32'h00A00093);

    // partial last word
    reload = 1; step(); reload = 0;
    chk("t3 ld_ready", 32'(ld_ready), 1);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(0, 0);
    chk("t3 ram0", ram[0], 32'h44332211);
    chk("t3 ram1", ram[1], 32'h00000055);
    chk("t3 words_loaded", 32'(words_loaded), 2);

    // reload with a fetch in the same cycle
    fetch_req = 1; fetch_pc = 4; reload = 1; step();
    fetch_req = 0; reload = 0;
    chk("t5 valid", 32'(fetch_valid), 1);
    chk("t5 instr", fetch_instr, 32'h00000055);
    chk("t5 stall", 32'(fetch_stall), 1);
    chk("t5 ld_ready", 32'(ld_ready), 1);
    step();
    chk("t5 valid after", 32'(fetch_valid), 0);

    // overflow
    bq.delete();
    for (int i = 1; i <= 36; i++) bq.push_back(8'(i));
    send(0, 0);
    chk("t4 overflow", 32'(load_overflow), 1);
    chk("t4 words_loaded", 32'(words_loaded), 8);
    chk("t4 ram7", ram[7], 32'h201F1E1D);
    reload = 1; step(); reload = 0;
    chk("t4 overflow clr", 32'(load_overflow), 0);
    chk("t4 words clr", 32'(words_loaded), 0);

`ifdef IMEM_BOUNDS_CHECK_EN
    bq = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h90, 8'h00};
    send(0, 0);
    fetch_req = 1; fetch_pc = 8; #1;
    chk("t6 mem_en pc8", 32'(mem_en), 0);
    step();
    chk("t6 instr pc8", fetch_instr, NOP);
    chk("t6 fault pc8", 32'(fetch_fault), 1);
    fetch_pc = 2; #1;
    chk("t6 mem_en pc2", 32'(mem_en), 0);
    step();
    chk("t6 fault pc2", 32'(fetch_fault), 1);
    fetch_req = 0; step();
    reload = 1; step(); reload = 0;
`endif

    // randomized programs, reloads, fetch traffic and one mid-run reset
    for (int it = 0; it < 30; it++) begin
      bq.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) bq.push_back(8'($urandom));
      send(1, (it % 3 == 0) ? 8 : 0);
      for (int c = 0; c < 20; c++) begin
        fetch_req = 1'($urandom);
        fetch_pc  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
        ld_valid  = ($urandom_range(0, 3) == 0);
        ld_data   = 8'($urandom);
        ld_last   = ($urandom_range(0, 7) == 0);
        reload    = 0;
        step();
      end
      fetch_req = 0; ld_valid = 0; ld_last = 0;
      if (it == 15) begin
        #3 reset_n = 0;
        step(); step();
        reset_n = 1;
      end else begin
        reload = 1; step(); reload = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
- Owns the single-port instruction memory after reset and sequences it in two phases.
- BOOT phase: assembles a byte stream from the program loader into 32-bit little-endian words and writes them to consecutive word addresses from 0.
- RUN phase: serves CPU fetch requests with fixed 1-cycle latency.
- Sits between the loader, the fetch stage and the synchronous instruction RAM. It replaces hardwired program initialisation.

Parameters:
- DEPTH, 8, number of 32-bit words in the instruction RAM.
- AW, 3, word-address width; must equal clog2(DEPTH).
- NOP_INSTR, 32'h00000013, word returned for invalid fetches (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_last  in  1  marks final byte of program; qualified by ld_valid
- ld_ready  out  1  controller accepts byte
- reload  in  1  single-cycle pulse; restarts BOOT
- fetch_req  in  1  fetch request
- fetch_pc  in  32  byte address of the fetch
- fetch_stall  out  1  request not accepted this cycle
- fetch_valid  out  1  fetch_instr valid
- fetch_instr  out  32  fetched instruction
- load_done  out  1  high in RUN
- load_overflow  out  1  sticky: program exceeded DEPTH words
- words_loaded  out  AW+1  words written in last BOOT
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
Reset (asynchronous, reset_n low):
- State=BOOT, byte index=0, word address=0.
- All outputs 0 except: ld_ready=1, fetch_stall=1, fetch_instr=NOP_INSTR.

BOOT:
- ld_ready=1 and fetch_stall=1.
- Handshake: a byte is accepted when ld_valid&&ld_ready.
- Accepted bytes fill lanes 0..3 little-endian (byte 0 goes to bits [7:0]).
- On the 4th byte, or on ld_last: same cycle, mem_en=1, mem_we=1, mem_addr=word address, mem_wdata=assembled word. Unfilled upper lanes are zero. Then the word address increments and words_loaded increments.
- Accepted byte with ld_last: write the word if any lane is filled (including the last byte). Next state=RUN.
- If words_loaded==DEPTH, further bytes are accepted and dropped (no write) and load_overflow is set; ld_last still moves to RUN.
- fetch_req is ignored in BOOT; fetch_valid stays 0.

RUN:
- ld_ready=0, fetch_stall=0, load_done=1.
- fetch_req in cycle N: mem_en=1, mem_we=0, mem_addr=fetch_pc[AW+1:2].
- In cycle N+1: fetch_valid=1, fetch_instr=mem_rdata.
- Fully pipelined: one accepted fetch per cycle, back-to-back allowed. fetch_pc[1:0] is ignored.
- fetch_instr holds its last value when fetch_valid=0.

reload:
- A reload seen in RUN moves to BOOT next cycle. That cycle's fetch is still accepted and its response is still delivered in BOOT.
- Entering BOOT clears the byte index, word address, words_loaded and load_overflow.
- reload in BOOT restarts BOOT: partial bytes are discarded and nothing is written that cycle, even if a byte is presented. reload has priority over byte acceptance.

General:
- Reset mid-operation aborts everything. RAM contents are not cleared.
- No combinational path from fetch_req to fetch_stall.

Optional Feature:
Macro: IMEM_BOUNDS_CHECK_EN.
- Defined: adds output fetch_fault (1 bit, reset 0). A RUN fetch with fetch_pc[31:2] >= words_loaded, or fetch_pc[1:0] != 0, does not enable the RAM. In N+1 it returns fetch_valid=1, fetch_instr=NOP_INSTR, fetch_fault=1. fetch_fault is 0 for valid fetches.
- Undefined: no fetch_fault port. Addresses truncate to AW bits and alias.

Test Plan:
1. Reset, stream 8 bytes 0x93,0x00,0xA0,0x00,0x13,0x01,0x90,0x00 with ld_last on the 8th -> writes addr0=0x00A00093, addr1=0x00900113; words_loaded=2; load_done=1 the cycle after the last byte.
2. RUN, fetch_req with pc=0,4,0 on consecutive cycles -> fetch_valid for 3 cycles starting 1 cycle later; instr 0x00A00093, 0x00900113, 0x00A00093.
3. Stream 5 bytes 0x11,0x22,0x33,0x44,0x55 with ld_last on 0x55 -> writes 0x44332211 then 0x00000055; words_loaded=2.
4. DEPTH=8: stream 36 bytes -> 8 writes, last 4 bytes dropped, load_overflow=1, words_loaded=8; reload clears load_overflow.
5. reload pulse with fetch of pc=4 in the same cycle -> that fetch returns 1 cycle later; fetch_stall=1 thereafter; ld_ready=1.
6. IMEM_BOUNDS_CHECK_EN, words_loaded=2: fetch pc=8 and pc=2 -> fetch_instr=0x00000013, fetch_fault=1, mem_en stays 0.
